// File: rtl/cv32e40s_sffr_guard.sv
// ---------------------------------------------------------------------------
// cv32e40s_sffr_guard
//
// Write/check front-end for a pair of hardened flip-flop banks. The primary
// bank holds a WIDTH-bit value and the shadow bank holds its bitwise
// complement. This block drives both banks' D inputs (init, write, hold),
// watches both banks' Q outputs for complement integrity every RUN cycle,
// counts mismatch cycles and raises minor (per cycle) and major (persistent)
// alerts.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wr_valid_i        write request
//   wr_ready_o        write accepted when wr_valid_i & wr_ready_o (RUN only)
//   wr_data_i         write value
//   d_o, ds_o         primary / shadow bank D inputs
//   q_i, qs_i         primary / shadow bank Q outputs
//   rdata_o           protected value (combinational copy of q_i)
//   clear_i           leave ALERT and re-initialise
//   alert_minor_o     registered one-cycle pulse per mismatch cycle
//   alert_major_o     registered sticky major alert
//   err_cnt_o         saturating count of mismatch cycles
// ---------------------------------------------------------------------------
module cv32e40s_sffr_guard #(
  parameter int unsigned      WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int unsigned      PERSIST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] ds_o,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] qs_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             clear_i,
  output logic             alert_minor_o,
  output logic             alert_major_o,
  output logic [7:0]       err_cnt_o
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    ALERT = 2'd2
  } state_e;

  localparam logic [3:0] PERSIST_MAX = 4'(PERSIST_CYCLES);

  state_e     state, state_nxt;
  logic [3:0] persist, persist_nxt;
  logic       mismatch;
  logic       wr_fire;
  logic       major_set;

  assign rdata_o = q_i;

  // Next-state, bank D drive and integrity check. Holding recirculates each
  // bank's own Q, so a corrupted bit stays put until it is overwritten.
  always_comb begin
    state_nxt   = state;
    wr_ready_o  = 1'b0;
    d_o         = q_i;
    ds_o        = qs_i;
    mismatch    = 1'b0;
    persist_nxt = persist;
    major_set   = 1'b0;
    wr_fire     = 1'b0;

    unique case (state)
      INIT: begin
        d_o       = RESET_VALUE;
        ds_o      = ~RESET_VALUE;
        state_nxt = RUN;
      end
      RUN: begin
        wr_ready_o = 1'b1;
        wr_fire    = wr_valid_i;
        if (wr_fire) begin
          d_o  = wr_data_i;
          ds_o = ~wr_data_i;
        end
        mismatch = ((q_i ^ qs_i) != {WIDTH{1'b1}});
        if (mismatch) begin
          persist_nxt = (persist >= PERSIST_MAX) ? PERSIST_MAX : persist + 4'd1;
        end else begin
          persist_nxt = 4'd0;
        end
        if (mismatch && (persist_nxt >= PERSIST_MAX)) begin
          major_set = 1'b1;
          state_nxt = ALERT;
        end
      end
      ALERT: begin
        if (clear_i) begin
          persist_nxt = 4'd0;
          state_nxt   = INIT;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // State, persistence, counters and alert registers. The error count
  // survives a clear; only rst wipes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      persist       <= 4'd0;
      err_cnt_o     <= 8'd0;
      alert_minor_o <= 1'b0;
      alert_major_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      persist       <= persist_nxt;
      alert_minor_o <= mismatch;
      if (mismatch && (err_cnt_o != 8'hFF)) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
      if (major_set) begin
        alert_major_o <= 1'b1;
      end else if ((state == ALERT) && clear_i) begin
        alert_major_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40s_sffr_guard.sv
// ---------------------------------------------------------------------------
// tb_cv32e40s_sffr_guard
//
// Directed bench for cv32e40s_sffr_guard (WIDTH=8, RESET_VALUE=8'hA5,
// PERSIST_CYCLES=2). The two flop banks are modelled here as plain
// registers clocked from d_o/ds_o; faults are planted by XOR-ing a one-shot
// mask into a bank's D path, which corrupts the stored value like an upset.
// ---------------------------------------------------------------------------
module tb_cv32e40s_sffr_guard;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic [W-1:0] d;
  logic [W-1:0] ds;
  logic [W-1:0] q;
  logic [W-1:0] qs;
  logic [W-1:0] rdata;
  logic         clear;
  logic         alert_minor;
  logic         alert_major;
  logic [7:0]   err_cnt;

  logic [W-1:0] q_inj;
  logic [W-1:0] qs_inj;

  int checks = 0;
  int errors = 0;

  cv32e40s_sffr_guard #(
    .WIDTH         (W),
    .RESET_VALUE   (RV),
    .PERSIST_CYCLES(2)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .d_o          (d),
    .ds_o         (ds),
    .q_i          (q),
    .qs_i         (qs),
    .rdata_o      (rdata),
    .clear_i      (clear),
    .alert_minor_o(alert_minor),
    .alert_major_o(alert_major),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: each bank captures its D, with an optional upset mask
  always @(posedge clk) begin
    q  <= d ^ q_inj;
    qs <= ds ^ qs_inj;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [W-1:0] data,
                               input logic clr);
    wr_valid = valid;
    wr_data  = data;
    clear    = clr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    clear    = 1'b0;
    q_inj    = '0;
    qs_inj   = '0;

    // Reset held for three cycles
    tick(); tick(); tick();
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_minor", 32'(alert_minor), 32'd0);
    checkOutput("rst_major", 32'(alert_major), 32'd0);
    rst = 1'b0;
    #1;

    // Cycle 0: INIT
    checkOutput("init_d", 32'(d), 32'hA5);
    checkOutput("init_ds", 32'(ds), 32'h5A);
    checkOutput("init_ready", 32'(wr_ready), 32'd0);

    // Cycle 1: first RUN cycle
    tick();
    checkOutput("run_rdata", 32'(rdata), 32'hA5);
    checkOutput("run_ready", 32'(wr_ready), 32'd1);
    checkOutput("run_minor", 32'(alert_minor), 32'd0);
    checkOutput("run_major", 32'(alert_major), 32'd0);
    checkOutput("run_err_cnt", 32'(err_cnt), 32'd0);

    // Write 3C
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("wr_d", 32'(d), 32'h3C);
    checkOutput("wr_ds", 32'(ds), 32'hC3);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("wr_rdata", 32'(rdata), 32'h3C);
    checkOutput("wr_minor", 32'(alert_minor), 32'd0);

    // Single-cycle glitch on shadow bit0, repaired by a write of 00
    qs_inj = 8'h01;
    tick();
    qs_inj = 8'h00;
    checkOutput("glitch_qs", 32'(qs), 32'hC2);
    applyStimulus(1'b1, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("glitch_minor", 32'(alert_minor), 32'd1);
    checkOutput("glitch_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("glitch_major", 32'(alert_major), 32'd0);
    checkOutput("glitch_ready", 32'(wr_ready), 32'd1);
    checkOutput("glitch_rdata", 32'(rdata), 32'h00);
    tick();
    checkOutput("glitch_minor_end", 32'(alert_minor), 32'd0);
    checkOutput("glitch_err_hold", 32'(err_cnt), 32'd1);

    // Persistent fault: primary bit7 flipped and left in place
    q_inj = 8'h80;
    tick();
    q_inj = 8'h00;
    checkOutput("pers_rdata", 32'(rdata), 32'h80);
    tick();
    checkOutput("pers_minor1", 32'(alert_minor), 32'd1);
    checkOutput("pers_err1", 32'(err_cnt), 32'd2);
    checkOutput("pers_major_early", 32'(alert_major), 32'd0);
    tick();
    checkOutput("pers_minor2", 32'(alert_minor), 32'd1);
    checkOutput("pers_err2", 32'(err_cnt), 32'd3);
    checkOutput("pers_major", 32'(alert_major), 32'd1);
    checkOutput("pers_ready", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("alert_minor_off", 32'(alert_minor), 32'd0);
    checkOutput("alert_err_frozen", 32'(err_cnt), 32'd3);
    applyStimulus(1'b1, 8'h55, 1'b0);
    checkOutput("alert_hold_d", 32'(d), 32'h80);
    checkOutput("alert_hold_ds", 32'(ds), 32'hFF);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("alert_wr_ignored", 32'(rdata), 32'h80);
    checkOutput("alert_major_sticky", 32'(alert_major), 32'd1);
    checkOutput("alert_err_frozen2", 32'(err_cnt), 32'd3);

    // Clear out of ALERT
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("clr_init_d", 32'(d), 32'hA5);
    checkOutput("clr_major", 32'(alert_major), 32'd0);
    checkOutput("clr_ready", 32'(wr_ready), 32'd0);
    checkOutput("clr_err_kept", 32'(err_cnt), 32'd3);
    tick();
    checkOutput("clr_run_rdata", 32'(rdata), 32'hA5);
    checkOutput("clr_run_ready", 32'(wr_ready), 32'd1);
    checkOutput("clr_run_err", 32'(err_cnt), 32'd3);

    // clear in RUN has no effect
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("clr_ignored_ready", 32'(wr_ready), 32'd1);

    // 300 isolated glitches, each repaired by a write in the same cycle
    for (int i = 0; i < 300; i++) begin
      qs_inj = 8'h01;
      tick();
      qs_inj = 8'h00;
      applyStimulus(1'b1, 8'(i), 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (i == 9) begin
        checkOutput("sat_err_mid", 32'(err_cnt), 32'd13);
        checkOutput("sat_minor_mid", 32'(alert_minor), 32'd1);
      end
    end
    checkOutput("sat_err", 32'(err_cnt), 32'd255);
    checkOutput("sat_major", 32'(alert_major), 32'd0);
    checkOutput("sat_rdata", 32'(rdata), 32'd299 & 32'hFF);
    tick();
    checkOutput("sat_err_hold", 32'(err_cnt), 32'd255);
    checkOutput("sat_ready", 32'(wr_ready), 32'd1);

    // Reset asserted alongside a write of FF
    rst = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rstw_init_d", 32'(d), 32'hA5);
    checkOutput("rstw_ready", 32'(wr_ready), 32'd0);
    checkOutput("rstw_err", 32'(err_cnt), 32'd0);
    checkOutput("rstw_minor", 32'(alert_minor), 32'd0);
    tick();
    checkOutput("rstw_rdata", 32'(rdata), 32'hA5);
    checkOutput("rstw_run_ready", 32'(wr_ready), 32'd1);
    tick();
    checkOutput("rstw_no_minor", 32'(alert_minor), 32'd0);
    checkOutput("rstw_err_zero", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the bench can never run away
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
